// File: rtl/huffman_in_packer.sv
// huffman_in_packer: byte-stream front end for huffman_encoder_v5.
// Packs accepted bytes big-endian into 32-bit words and hands them to the
// encoder under its in_full backpressure. It also derives stat_end, in_end
// and the final-word byte mask from an internal byte counter.
// Optional macro HUFF_PACK_LEN_EN exports the live byte count (src_len)
// and a one-cycle strobe (src_len_valid) on the final word transfer.
module huffman_in_packer #(
    parameter int STAT_LEN = 8192,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              enc_in_full,
    output logic [31:0]       enc_data,
    output logic              enc_valid,
    output logic [2:0]        enc_last_mask,
    output logic              enc_stat_end,
    output logic              enc_in_end,
    output logic              busy
`ifdef HUFF_PACK_LEN_EN
    ,
    output logic [CNT_W-1:0]  src_len,
    output logic              src_len_valid
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_STAT_LEN = CNT_W'(STAT_LEN);
    localparam logic [CNT_W-1:0] LP_CNT_MAX  = '1;

    state_t            r_state;
    logic              r_busy;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_idx;
    logic [31:0]       r_pack;
    logic              r_pending;
    logic              r_stat_end;
    logic              r_in_end;
    logic [2:0]        r_last_mask;

    logic              w_xfer;
    logic              w_accept;
    logic              w_word_done;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [31:0]       w_pack_nxt;
    logic [2:0]        w_mask;

    // A pending word is offered whenever the encoder FIFO has room; a start
    // in the same cycle drops it instead of transferring it.
    assign w_xfer      = r_pending & ~enc_in_full & ~start;
    // Bytes are accepted while no word waits, or in the cycle the waiting
    // word leaves, which sustains one word every four cycles.
    assign s_ready     = (r_state == RUN) & (~r_pending | ~enc_in_full) & ~start;
    assign w_accept    = s_valid & s_ready;
    assign w_word_done = (r_idx == 2'd3) | s_last;
    // The counter sticks at its maximum rather than wrapping.
    assign w_cnt_nxt   = (r_cnt == LP_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
    // Byte count mod 4 of the final word, with a full word reported as 4.
    assign w_mask      = (r_idx == 2'd3) ? 3'd4 : {1'b0, r_idx} + 3'd1;

    assign enc_valid     = w_xfer;
    assign enc_data      = r_pack;
    assign enc_last_mask = r_last_mask;
    assign enc_stat_end  = r_stat_end;
    assign enc_in_end    = r_in_end;
    assign busy          = r_busy;

`ifdef HUFF_PACK_LEN_EN
    assign src_len       = r_cnt;
    assign src_len_valid = w_xfer & r_in_end;
`endif

    // Place the incoming byte into lane 3-idx; lane 3 starts a fresh word so
    // the unused low lanes of a partial word read as zero.
    always_comb begin
        w_pack_nxt = r_pack;
        case (r_idx)
            2'd0: w_pack_nxt = {s_data, 24'h000000};
            2'd1: w_pack_nxt[23:16] = s_data;
            2'd2: w_pack_nxt[15:8]  = s_data;
            default: w_pack_nxt[7:0] = s_data;
        endcase
    end

    // Stream control FSM: packing, word hand-off and end-of-stream flags.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_pack      <= 32'h0;
            r_pending   <= 1'b0;
            r_stat_end  <= 1'b0;
            r_in_end    <= 1'b0;
            r_last_mask <= 3'd0;
        end else if (start) begin
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_pack      <= 32'h0;
            r_pending   <= 1'b0;
            r_stat_end  <= 1'b0;
            r_in_end    <= 1'b0;
            r_last_mask <= 3'd0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_xfer) begin
                        r_pending <= 1'b0;
                    end
                    if (w_accept) begin
                        r_cnt  <= w_cnt_nxt;
                        r_idx  <= r_idx + 2'd1;
                        r_pack <= w_pack_nxt;
                        if (w_word_done) begin
                            r_pending <= 1'b1;
                            r_idx     <= 2'd0;
                            if ((w_cnt_nxt >= LP_STAT_LEN) || s_last) begin
                                r_stat_end <= 1'b1;
                            end
                        end
                        if (s_last) begin
                            r_in_end    <= 1'b1;
                            r_last_mask <= w_mask;
                            r_state     <= LAST;
                        end
                    end
                end
                LAST: begin
                    if (w_xfer) begin
                        r_pending <= 1'b0;
                        r_busy    <= 1'b0;
                        r_state   <= DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_in_packer.sv
// Directed bench for huffman_in_packer with a queue-based scoreboard.
module tb_huffman_in_packer;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        enc_in_full;
    logic [31:0] enc_data;
    logic        enc_valid;
    logic [2:0]  enc_last_mask;
    logic        enc_stat_end;
    logic        enc_in_end;
    logic        busy;
`ifdef HUFF_PACK_LEN_EN
    logic [31:0] src_len;
    logic        src_len_valid;
`endif

    huffman_in_packer #(.STAT_LEN(8192), .CNT_W(32)) dut (
        .clk           (clk),
        .rstN          (rstN),
        .start         (start),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .enc_in_full   (enc_in_full),
        .enc_data      (enc_data),
        .enc_valid     (enc_valid),
        .enc_last_mask (enc_last_mask),
        .enc_stat_end  (enc_stat_end),
        .enc_in_end    (enc_in_end),
        .busy          (busy)
`ifdef HUFF_PACK_LEN_EN
        ,
        .src_len       (src_len),
        .src_len_valid (src_len_valid)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  m;
        logic        s;
        logic        e;
        logic [31:0] len;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          total = 0;
    int          bad = 0;
    bit          chk_after_last = 1'b0;
    logic [2:0]  held_mask = 3'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [2:0] m, input logic s,
                        input logic e, input logic [31:0] len);
        exp_t x;
        x.d = d; x.m = m; x.s = s; x.e = e; x.len = len;
        q.push_back(x);
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte was taken.
    task automatic send_byte(input logic [7:0] b, input logic l);
        int n = 0;
        s_data = b; s_valid = 1'b1; s_last = l;
        @(negedge clk);
        while (!s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            total++; bad++;
            $display("FAIL send_timeout got=stalled want=accept byte=%h", b);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_end_clr", enc_in_end, 0);
        chk("start_stat_clr", enc_stat_end, 0);
        chk("start_busy", busy, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            total++; bad++;
            $display("FAIL done_timeout got=busy want=idle");
        end
        @(posedge clk); #1;
        chk("queue_drained", q.size(), 0);
    endtask

    // Monitor: every transfer is checked against the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_after_last) begin
                chk("busy_fall", busy, 0);
                chk("in_end_hold", enc_in_end, 1);
                chk("mask_hold", enc_last_mask, held_mask);
                chk_after_last = 1'b0;
            end
            if (enc_valid === 1'b1) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_word got=%h want=none", enc_data);
                end else begin
                    cur = q.pop_front();
                    chk("word_data", enc_data, cur.d);
                    chk("word_mask", enc_last_mask, cur.m);
                    chk("word_stat_end", enc_stat_end, cur.s);
                    chk("word_in_end", enc_in_end, cur.e);
                    if (cur.e) begin
                        chk("busy_at_last", busy, 1);
                        held_mask = cur.m;
                        chk_after_last = 1'b1;
`ifdef HUFF_PACK_LEN_EN
                        chk("src_len", src_len, cur.len);
                        chk("src_len_valid", src_len_valid, 1);
`endif
                    end
                end
            end
        end
    end

    initial begin
        rstN = 1'b0; start = 1'b0; s_data = 8'h0; s_valid = 1'b0; s_last = 1'b0;
        enc_in_full = 1'b0;
        #12;
        chk("rst_enc_valid", enc_valid, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_enc_data", enc_data, 0);
        chk("rst_stat_end", enc_stat_end, 0);
        chk("rst_in_end", enc_in_end, 0);
        chk("rst_mask", enc_last_mask, 0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        chk("idle_s_ready", s_ready, 0);

        // 8 bytes, two full words
        do_start();
        push(32'h01020304, 3'd0, 1'b0, 1'b0, 0);
        push(32'h05060708, 3'd4, 1'b1, 1'b1, 8);
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        wait_done();

        // 5 bytes, partial final word
        do_start();
        push(32'hAAABACAD, 3'd0, 1'b0, 1'b0, 0);
        push(32'hAE000000, 3'd1, 1'b1, 1'b1, 5);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hAA + i), i == 4);
        wait_done();

        // 8200 bytes crossing the statistics window
        do_start();
        for (int w = 1; w <= 2050; w++) begin
            push({8'(4*w-3), 8'(4*w-2), 8'(4*w-1), 8'(4*w)},
                 (w == 2050) ? 3'd4 : 3'd0,
                 (4*w >= 8192) || (w == 2050),
                 w == 2050, 8200);
        end
        for (int i = 1; i <= 8200; i++) send_byte(8'(i), i == 8200);
        wait_done();

        // Backpressure with a full word pending
        do_start();
        push(32'h10111213, 3'd0, 1'b0, 1'b0, 0);
        push(32'h14150000, 3'd2, 1'b1, 1'b1, 6);
        enc_in_full = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'(8'h10 + i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_enc_valid", enc_valid, 0);
            chk("bp_s_ready", s_ready, 0);
            chk("bp_enc_data", enc_data, 32'h10111213);
        end
        @(posedge clk); #1;
        enc_in_full = 1'b0;
        @(negedge clk);
        chk("bp_release_xfer", enc_valid, 1);
        @(posedge clk); #1;
        send_byte(8'h14, 1'b0);
        send_byte(8'h15, 1'b1);
        wait_done();

        // Reset in the middle of a word
        do_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        rstN = 1'b0;
        #2;
        chk("mid_rst_enc_valid", enc_valid, 0);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_enc_data", enc_data, 0);
        chk("mid_rst_stat_end", enc_stat_end, 0);
        chk("mid_rst_in_end", enc_in_end, 0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(posedge clk); #1;
        do_start();
        push(32'h11223344, 3'd4, 1'b1, 1'b1, 4);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b1);
        wait_done();

        // Restart from DONE with a one-byte stream
        do_start();
        push(32'h7F000000, 3'd1, 1'b1, 1'b1, 1);
        send_byte(8'h7F, 1'b1);
        wait_done();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/huffman_in_packer.md
Name: huffman_in_packer

Overview:
- Upstream feeder for huffman_encoder_v5.
- Accepts a byte stream with valid/ready handshake and packs it big-endian into 32-bit words; first byte of each word goes to [31:24].
- Drives the encoder's in_data/in_valid/last_mask/stat_end/in_end inputs and honours its in_full backpressure.
- Counts bytes so stat_end and the final-word mask are generated in hardware rather than by software.

Parameters:
- STAT_LEN, 8192: byte count at which the statistics window closes.
- CNT_W, 32: width of the internal byte counter.

Ports:
- clk  in  1  clock.
- rstN  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse; clears all state and begins a new stream.
- s_data  in  8  input byte.
- s_valid  in  1  s_data valid.
- s_last  in  1  qualifies s_data as the final byte of the stream.
- s_ready  out  1  byte accepted when s_valid & s_ready.
- enc_in_full  in  1  encoder input FIFO full.
- enc_data  out  32  packed word, connects to in_data.
- enc_valid  out  1  word transfer strobe, connects to in_valid.
- enc_last_mask  out  3  valid bytes in final word (1..4; 4 = 3'b100), connects to last_mask.
- enc_stat_end  out  1  statistics window closed, connects to stat_end.
- enc_in_end  out  1  source end, connects to in_end.
- busy  out  1  high from start until the final word is transferred.

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter 0; pack register 0; byte-lane index 0.
- The polarity and synchronicity of rstN are fixed. Asserting rstN mid-stream discards the partial word immediately.
- States:
  - IDLE: s_ready=0. start moves to RUN and sets busy=1.
  - RUN: s_ready = ~word_pending. Each accepted byte goes into lane 3-idx; idx increments and the counter increments.
    - On the 4th byte, or on s_last, set word_pending. A partial word has its unused low lanes zeroed.
    - s_last moves to LAST.
  - LAST: s_ready=0. Waits for the pending word to transfer, then goes to DONE.
  - DONE: busy=0, s_ready=0. Only start leaves DONE.
- Word transfer:
  - enc_valid = word_pending & ~enc_in_full (combinational gating on enc_in_full).
  - A word transfers in every cycle enc_valid=1. word_pending clears in that cycle.
  - enc_data is held stable while pending.
  - In RUN, a byte may be accepted in the same cycle the pending word transfers (back-to-back throughput of 1 word / 4 cycles minimum).
- enc_stat_end:
  - Set, coincident with enc_valid, on the first word whose end byte count >= STAT_LEN. With STAT_LEN=8192 this is the word carrying byte 8192.
  - Also set on the final word if the stream is shorter than STAT_LEN.
  - Sticky until start or reset.
- enc_in_end and enc_last_mask:
  - Driven coincident with the final word's enc_valid.
  - Held in DONE until start.
  - enc_last_mask = ((count-1) mod 4)+1. Before the final word it is 0.
- start in any state: synchronous clear of counter, idx, pending, stat_end and in_end; enters RUN. A pending word is dropped.
- Simultaneous start & s_valid: the byte is not accepted (s_ready=0 that cycle).
- Counter saturates at 2^CNT_W-1. It does not wrap.
- Zero-length streams are not supported: software must send at least one byte with s_last.

Optional Feature:
- Macro HUFF_PACK_LEN_EN.
- Defined: adds ports src_len (out, CNT_W) and src_len_valid (out, 1).
  - src_len holds the live byte count.
  - src_len_valid pulses for one cycle when the final word transfers; src_len then holds until start.
  - Software writes this value into the frame-length field at byte offset 4 of the output frame.
- Undefined: both ports are absent and the count is used internally only.

Test Plan:
- 8 bytes 0x01..0x08 with s_last on 0x08, no backpressure:
  - words 0x01020304 then 0x05060708;
  - the second word carries in_end=1, last_mask=3'b100, stat_end=1 (short stream).
- 5 bytes 0xAA..0xAE:
  - word 0xAAABACAD then 0xAE000000 with last_mask=1;
  - busy falls the cycle after the final transfer.
- 8200 bytes, STAT_LEN=8192:
  - stat_end first high on word 2048 (bytes 8189..8192) and stays high;
  - last word has last_mask=4;
  - src_len=8200 with the macro.
- enc_in_full held high for 10 cycles with a word pending:
  - enc_valid=0 and s_ready=0 throughout;
  - enc_data stable;
  - transfer in the first cycle enc_in_full=0;
  - no byte lost.
- rstN pulsed low after 3 of 4 bytes:
  - outputs 0 immediately;
  - no word emitted;
  - after start, a fresh stream of 0x11223344 packs correctly.
- start asserted in DONE, then 1 byte 0x7F with s_last:
  - word 0x7F000000 with last_mask=1, stat_end=1, in_end=1.
